// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single memory port with one
// outstanding transaction and bounded data-side priority to prevent fetch starvation.
module mem_arbiter #(
  parameter int unsigned MAX_DGRANT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  dstreak_q, dstreak_d;

  logic        ibuf_valid_q, ibuf_valid_d;
  logic [31:0] ibuf_addr_q, ibuf_addr_d;
  logic [3:0]  ibuf_rmask_q, ibuf_rmask_d;

  logic        dbuf_valid_q, dbuf_valid_d;
  logic [31:0] dbuf_addr_q, dbuf_addr_d;
  logic [3:0]  dbuf_rmask_q, dbuf_rmask_d;
  logic [3:0]  dbuf_wmask_q, dbuf_wmask_d;
  logic [31:0] dbuf_wdata_q, dbuf_wdata_d;

  logic [31:0] last_addr_q, last_addr_d;
  logic [31:0] last_wdata_q, last_wdata_d;

  logic        issue_i, issue_d;
  logic        i_blocked, d_blocked;

  // Next-state: arbitration, issue bookkeeping and request capture
  always_comb begin
    state_d      = state_q;
    dstreak_d    = dstreak_q;
    ibuf_valid_d = ibuf_valid_q;
    ibuf_addr_d  = ibuf_addr_q;
    ibuf_rmask_d = ibuf_rmask_q;
    dbuf_valid_d = dbuf_valid_q;
    dbuf_addr_d  = dbuf_addr_q;
    dbuf_rmask_d = dbuf_rmask_q;
    dbuf_wmask_d = dbuf_wmask_q;
    dbuf_wdata_d = dbuf_wdata_q;
    last_addr_d  = last_addr_q;
    last_wdata_d = last_wdata_q;
    issue_i      = 1'b0;
    issue_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // Data side wins unless it has used up its streak while a fetch waits.
        if (dbuf_valid_q && !(ibuf_valid_q && (dstreak_q == 3'(MAX_DGRANT)))) begin
          issue_d = 1'b1;
        end else if (ibuf_valid_q) begin
          issue_i = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      IBUSY: begin
        if (mem_resp) state_d = IDLE;
        else          state_d = IBUSY;
      end
      DBUSY: begin
        if (mem_resp) state_d = IDLE;
        else          state_d = DBUSY;
      end
      default: state_d = IDLE;
    endcase

    if (issue_i) begin
      state_d      = IBUSY;
      ibuf_valid_d = 1'b0;
      dstreak_d    = 3'd0;
      last_addr_d  = ibuf_addr_q;
    end else if (issue_d) begin
      state_d      = DBUSY;
      dbuf_valid_d = 1'b0;
      dstreak_d    = (dstreak_q < 3'(MAX_DGRANT)) ? dstreak_q + 3'd1 : dstreak_q;
      last_addr_d  = dbuf_addr_q;
      last_wdata_d = dbuf_wdata_q;
    end else begin
      dstreak_d    = dstreak_q;
    end

    // The completing cycle no longer counts as in flight, so a new request may land then.
    i_blocked = ibuf_valid_q || ((state_q == IBUSY) && !mem_resp);
    d_blocked = dbuf_valid_q || ((state_q == DBUSY) && !mem_resp);

    if ((imem_rmask != 4'd0) && !i_blocked) begin
      ibuf_valid_d = 1'b1;
      ibuf_addr_d  = imem_addr;
      ibuf_rmask_d = imem_rmask;
    end else begin
      ibuf_addr_d  = ibuf_addr_d;
    end

    if (((dmem_rmask != 4'd0) || (dmem_wmask != 4'd0)) && !d_blocked) begin
      dbuf_valid_d = 1'b1;
      dbuf_addr_d  = dmem_addr;
      dbuf_rmask_d = (dmem_wmask != 4'd0) ? 4'd0 : dmem_rmask;
      dbuf_wmask_d = dmem_wmask;
      dbuf_wdata_d = dmem_wdata;
    end else begin
      dbuf_addr_d  = dbuf_addr_d;
    end
  end

  // Output drive: issue pulse on the unified port and owner-routed responses
  always_comb begin
    mem_addr  = last_addr_d;
    mem_wdata = last_wdata_d;
    if (issue_i) begin
      mem_rmask = ibuf_rmask_q;
      mem_wmask = 4'd0;
    end else if (issue_d) begin
      mem_rmask = dbuf_rmask_q;
      mem_wmask = dbuf_wmask_q;
    end else begin
      mem_rmask = 4'd0;
      mem_wmask = 4'd0;
    end
    imem_resp  = (state_q == IBUSY) && mem_resp;
    dmem_resp  = (state_q == DBUSY) && mem_resp;
    imem_rdata = imem_resp ? mem_rdata : 32'd0;
    dmem_rdata = dmem_resp ? mem_rdata : 32'd0;
  end

  // State, streak counter, pending buffers and held port values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dstreak_q    <= 3'd0;
      ibuf_valid_q <= 1'b0;
      ibuf_addr_q  <= 32'd0;
      ibuf_rmask_q <= 4'd0;
      dbuf_valid_q <= 1'b0;
      dbuf_addr_q  <= 32'd0;
      dbuf_rmask_q <= 4'd0;
      dbuf_wmask_q <= 4'd0;
      dbuf_wdata_q <= 32'd0;
      last_addr_q  <= 32'd0;
      last_wdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      dstreak_q    <= dstreak_d;
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_addr_q  <= ibuf_addr_d;
      ibuf_rmask_q <= ibuf_rmask_d;
      dbuf_valid_q <= dbuf_valid_d;
      dbuf_addr_q  <= dbuf_addr_d;
      dbuf_rmask_q <= dbuf_rmask_d;
      dbuf_wmask_q <= dbuf_wmask_d;
      dbuf_wdata_q <= dbuf_wdata_d;
      last_addr_q  <= last_addr_d;
      last_wdata_q <= last_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MAX_DGRANT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_addr   (mem_addr),
    .mem_rmask  (mem_rmask),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_addr = 32'd0; imem_rmask = 4'd0;
    dmem_addr = 32'd0; dmem_rmask = 4'd0; dmem_wmask = 4'd0; dmem_wdata = 32'd0;
    mem_rdata = 32'd0; mem_resp = 1'b0;
    step();
    step();
    chk("rst_mem_rmask", 32'(mem_rmask), 32'd0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_imem_resp", 32'(imem_resp), 32'd0);
    chk("rst_dmem_resp", 32'(dmem_resp), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'd0);
    chk("rst_dstreak", 32'(dut.dstreak_q), 32'd0);
    rst_n = 1'b1;
    step();

    // Single fetch
    imem_rmask = 4'hF; imem_addr = 32'h1000;
    step();
    imem_rmask = 4'd0;
    chk("f_issue_rmask", 32'(mem_rmask), 32'hF);
    chk("f_issue_addr", mem_addr, 32'h1000);
    step();
    chk("f_busy_rmask", 32'(mem_rmask), 32'd0);
    chk("f_hold_addr", mem_addr, 32'h1000);
    step();
    step();
    mem_resp = 1'b1; mem_rdata = 32'h13;
    #1;
    chk("f_imem_resp", 32'(imem_resp), 32'd1);
    chk("f_imem_rdata", imem_rdata, 32'h13);
    chk("f_dmem_resp", 32'(dmem_resp), 32'd0);
    chk("f_dmem_rdata", dmem_rdata, 32'd0);
    step();
    mem_resp = 1'b0;
    #1;
    chk("f_after_resp", 32'(imem_resp), 32'd0);
    chk("f_after_rdata", imem_rdata, 32'd0);
    chk("f_state_idle", 32'(dut.state_q), 32'd0);

    // Mixed masks become a store
    dmem_rmask = 4'hF; dmem_wmask = 4'h1; dmem_addr = 32'h40; dmem_wdata = 32'h55;
    step();
    dmem_rmask = 4'd0; dmem_wmask = 4'd0;
    chk("mix_wmask", 32'(mem_wmask), 32'h1);
    chk("mix_rmask", 32'(mem_rmask), 32'd0);
    chk("mix_addr", mem_addr, 32'h40);
    chk("mix_wdata", mem_wdata, 32'h55);
    step();
    mem_resp = 1'b1; mem_rdata = 32'h0;
    #1;
    chk("mix_dmem_resp", 32'(dmem_resp), 32'd1);
    step();
    mem_resp = 1'b0;

    // Simultaneous fetch and store: store first, fetch after its response
    imem_rmask = 4'hF; imem_addr = 32'h2000;
    dmem_wmask = 4'h3; dmem_addr = 32'h8000; dmem_wdata = 32'hBEEF;
    step();
    imem_rmask = 4'd0; dmem_wmask = 4'd0;
    chk("sim_st_wmask", 32'(mem_wmask), 32'h3);
    chk("sim_st_rmask", 32'(mem_rmask), 32'd0);
    chk("sim_st_addr", mem_addr, 32'h8000);
    chk("sim_st_wdata", mem_wdata, 32'hBEEF);
    step();
    chk("sim_busy_rmask", 32'(mem_rmask), 32'd0);
    step();
    mem_resp = 1'b1; mem_rdata = 32'hDEAD;
    #1;
    chk("sim_st_dresp", 32'(dmem_resp), 32'd1);
    chk("sim_st_drdata", dmem_rdata, 32'hDEAD);
    chk("sim_st_iresp", 32'(imem_resp), 32'd0);
    chk("sim_st_irdata", imem_rdata, 32'd0);
    chk("sim_no_issue_in_resp", 32'(mem_rmask), 32'd0);
    step();
    mem_resp = 1'b0;
    #1;
    chk("sim_f_rmask", 32'(mem_rmask), 32'hF);
    chk("sim_f_wmask", 32'(mem_wmask), 32'd0);
    chk("sim_f_addr", mem_addr, 32'h2000);
    chk("sim_f_wdata_held", mem_wdata, 32'hBEEF);
    step();
    mem_resp = 1'b1; mem_rdata = 32'h77;
    #1;
    chk("sim_f_iresp", 32'(imem_resp), 32'd1);
    chk("sim_f_irdata", imem_rdata, 32'h77);
    step();
    mem_resp = 1'b0;
    #1;
    chk("sim_dstreak_clr", 32'(dut.dstreak_q), 32'd0);

    // Starvation guard: four data grants, then the waiting fetch
    imem_rmask = 4'hF; imem_addr = 32'h3000;
    dmem_rmask = 4'hF; dmem_addr = 32'h9000;
    step();
    imem_rmask = 4'd0;
    for (int g = 0; g < 5; g++) begin
      if (g < 4) begin
        chk($sformatf("stv_d%0d_addr", g), mem_addr, 32'h9000);
        chk($sformatf("stv_d%0d_rmask", g), 32'(mem_rmask), 32'hF);
      end else begin
        chk("stv_i_addr", mem_addr, 32'h3000);
        chk("stv_i_rmask", 32'(mem_rmask), 32'hF);
      end
      step();
      mem_resp = 1'b1; mem_rdata = 32'(g);
      #1;
      if (g < 4) chk($sformatf("stv_d%0d_resp", g), 32'(dmem_resp), 32'd1);
      else       chk("stv_i_resp", 32'(imem_resp), 32'd1);
      step();
      mem_resp = 1'b0;
      #1;
    end
    dmem_rmask = 4'd0;
    chk("stv_dstreak_zero", 32'(dut.dstreak_q), 32'd0);
    chk("stv_drain_addr", mem_addr, 32'h9000);
    step();
    mem_resp = 1'b1;
    #1;
    chk("stv_drain_resp", 32'(dmem_resp), 32'd1);
    step();
    mem_resp = 1'b0;
    #1;
    chk("stv_dstreak_one", 32'(dut.dstreak_q), 32'd1);

    // Dropped second fetch while the first is still pending
    imem_rmask = 4'hF; imem_addr = 32'h4000;
    step();
    imem_addr = 32'h5000;
    #1;
    chk("drop_issue_addr", mem_addr, 32'h4000);
    chk("drop_issue_rmask", 32'(mem_rmask), 32'hF);
    step();
    imem_rmask = 4'd0;
    chk("drop_busy_rmask", 32'(mem_rmask), 32'd0);
    step();
    mem_resp = 1'b1; mem_rdata = 32'hAB;
    #1;
    chk("drop_iresp", 32'(imem_resp), 32'd1);
    step();
    mem_resp = 1'b0;
    #1;
    chk("drop_no_reissue", 32'(mem_rmask), 32'd0);
    step();
    chk("drop_no_reissue2", 32'(mem_rmask), 32'd0);
    chk("drop_addr_held", mem_addr, 32'h4000);

    // Reset during a data transaction, then a stale response
    dmem_rmask = 4'hF; dmem_addr = 32'hA000;
    step();
    dmem_rmask = 4'd0;
    chk("rb_issue_rmask", 32'(mem_rmask), 32'hF);
    step();
    chk("rb_state_dbusy", 32'(dut.state_q), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rb_state_idle", 32'(dut.state_q), 32'd0);
    chk("rb_addr_zero", mem_addr, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    mem_resp = 1'b1; mem_rdata = 32'h99;
    #1;
    chk("rb_no_dresp", 32'(dmem_resp), 32'd0);
    chk("rb_no_iresp", 32'(imem_resp), 32'd0);
    chk("rb_drdata_zero", dmem_rdata, 32'd0);
    chk("rb_mem_rmask", 32'(mem_rmask), 32'd0);
    chk("rb_mem_wmask", 32'(mem_wmask), 32'd0);
    step();
    mem_resp = 1'b0;
    #1;
    chk("rb_state_after", 32'(dut.state_q), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
